// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch front end.
package rv32i_fetch_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0]     INST_NOP         = 32'h0000_0013;

   // Fetch state is the concatenation {infl_v, hold_v}
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_HOLD    = 2'b01,
      ST_STREAM  = 2'b10,
      ST_ILLEGAL = 2'b11
   } fetch_state_e;

   // Force a byte address onto a word boundary
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// One-entry hold register that parks an instruction while decode stalls.
module rv32i_fetch_skid
   import rv32i_fetch_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              drain,
   input  logic              flush,
   input  logic [DWIDTH-1:0] in_data,
   input  logic [XLEN-1:0]   in_pc,
   output logic              hold_v,
   output logic [DWIDTH-1:0] hold_data,
   output logic [XLEN-1:0]   hold_pc
);

   // Hold valid: flush wins, then capture on a stall, then drain on accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        hold_v <= 1'b0;
      else if (flush)   hold_v <= 1'b0;
      else if (capture) hold_v <= 1'b1;
      else if (drain)   hold_v <= 1'b0;
   end

   // Hold payload: loaded only when a stalled instruction is parked
   always_ff @(posedge clk) begin
      if (capture && !flush) begin
         hold_data <= in_data;
         hold_pc   <= in_pc;
      end
   end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, hides the 1-cycle imem
// read latency and feeds decode over valid/ready with stall and redirect.
module rv32i_fetch_ctrl
   import rv32i_fetch_pkg::*;
#(
   parameter int              AWIDTH   = 7,
   parameter int              DWIDTH   = 32,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [AWIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DWIDTH-1:0] inst_data,
   output logic [XLEN-1:0]   inst_pc,
   output logic              fetch_err
);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic              infl_v, infl_v_d;
   logic [XLEN-1:0]   infl_pc, infl_pc_d;
   logic              err_d;
   logic              issue, capture, drain, flush;
   logic              hold_v;
   logic [DWIDTH-1:0] hold_data;
   logic [XLEN-1:0]   hold_pc;
   fetch_state_e      state;

   assign state     = fetch_state_e'({infl_v, hold_v});
   assign imem_addr = pc_q[AWIDTH+1:2];

   // Control registers: PC, in-flight flag and sticky misalignment flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         infl_v    <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         infl_v    <= infl_v_d;
         fetch_err <= err_d;
      end
   end

   // PC of the word the imem is reading this cycle
   always_ff @(posedge clk) begin
      infl_pc <= infl_pc_d;
   end

   // Next-state: redirect first, then issue/stall decisions per state
   always_comb begin
      issue     = 1'b0;
      capture   = 1'b0;
      drain     = 1'b0;
      flush     = 1'b0;
      pc_d      = pc_q;
      infl_v_d  = 1'b0;
      infl_pc_d = infl_pc;
      err_d     = fetch_err;
      if (redirect_valid) begin
         flush = 1'b1;
         pc_d  = align_pc(redirect_pc);
         err_d = fetch_err | (redirect_pc[1:0] != 2'b00);
      end else begin
         case (state)
            ST_IDLE:    issue = 1'b1;
            ST_STREAM: begin
               if (inst_ready) issue   = 1'b1;
               else            capture = 1'b1;
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  drain = 1'b1;
                  issue = 1'b1;
               end
            end
            ST_ILLEGAL: ;
            default:    ;
         endcase
         // Re-presenting the held address while not issuing is harmless
         if (issue) begin
            pc_d      = pc_q + 32'd4;
            infl_v_d  = 1'b1;
            infl_pc_d = pc_q;
         end
      end
   end

   rv32i_fetch_skid #(
      .DWIDTH (DWIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture),
      .drain     (drain),
      .flush     (flush),
      .in_data   (imem_data),
      .in_pc     (infl_pc),
      .hold_v    (hold_v),
      .hold_data (hold_data),
      .hold_pc   (hold_pc)
   );

   // A redirect kills the presented instruction in the same cycle
   assign inst_valid = (infl_v | hold_v) & ~redirect_valid;
   assign inst_data  = hold_v ? hold_data : (infl_v ? imem_data : DWIDTH'(INST_NOP));
   assign inst_pc    = hold_v ? hold_pc : infl_pc;

   // Streaming and holding are mutually exclusive
   a_state_legal: assert property (@(posedge clk) disable iff (reset) !(infl_v && hold_v));

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Directed + random bench for rv32i_fetch_ctrl with an imem model
// preloaded as mem[i] = 32'hA000_0000 + i and a PC-ordered scoreboard.
module tb_rv32i_fetch_ctrl;

   localparam int          AWIDTH   = 7;
   localparam int          DWIDTH   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic [AWIDTH-1:0] imem_addr;
   logic [DWIDTH-1:0] imem_data;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DWIDTH-1:0] inst_data;
   logic [31:0]       inst_pc;
   logic              fetch_err;

   logic [31:0] mem [0:(1<<AWIDTH)-1];
   logic [31:0] exp_q [$];
   logic [31:0] tail_pc;
   int          nvec = 0;
   int          nmis = 0;

   always #5 clk = ~clk;

   rv32i_fetch_ctrl #(
      .AWIDTH   (AWIDTH),
      .DWIDTH   (DWIDTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fetch_err      (fetch_err)
   );

   // Synchronous-read instruction memory, port A
   always @(posedge clk) imem_data <= mem[imem_addr];

   function automatic logic [31:0] exp_data(input logic [31:0] pc);
      return 32'hA000_0000 + {25'd0, pc[8:2]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, inst_valid, 1'b1);
      chk({tag, "_pc"}, inst_pc, pc);
      chk({tag, "_data"}, inst_data, exp_data(pc));
   endtask

   // Expected accept order restarts at a new target after reset/redirect
   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      tail_pc = pc - 32'd4;
   endtask

   task automatic topup();
      while (exp_q.size() < 4) begin
         tail_pc = tail_pc + 32'd4;
         exp_q.push_back(tail_pc);
      end
   endtask

   // Drive one cycle's inputs at negedge, sample outputs 1ns later.
   // ev: 0/1 = required inst_valid, -1 = not checked.
   task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc, input int ev);
      logic [31:0] e;
      @(negedge clk);
      topup();
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      if (ev >= 0) chk("valid", inst_valid, ev[0]);
      if (inst_valid && inst_ready) begin
         e = exp_q.pop_front();
         chk("sb_pc", inst_pc, e);
         chk("sb_data", inst_data, exp_data(e));
      end
      if (rv) restart({rpc[31:2], 2'b00});
   endtask

   initial begin
      logic        prev_v, prev_r, prev_rv;
      logic [31:0] prev_pc;
      logic        rdy, rv;
      logic [31:0] rpc;

      for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = 32'hA000_0000 + i;
      reset          = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_addr", imem_addr, RESET_PC[AWIDTH+1:2]);

      // Release: the next edge issues RESET_PC and registers its word
      @(negedge clk);
      reset = 1'b0;
      restart(RESET_PC);
      #1;
      chk("rel_valid", inst_valid, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("first", 32'h0);
      repeat (3) tick(1'b1, 1'b0, 32'h0, 1);

      // Stall for 3 cycles with pc 0x10 presented
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1);
         chk_out("stall", 32'h10);
      end
      tick(1'b1, 1'b0, 32'h0, 1);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("no_bubble", 32'h14);

      // Park 0x18, then redirect to 0x40 from HOLD
      tick(1'b0, 1'b0, 32'h0, 1);
      tick(1'b1, 1'b1, 32'h40, 0);
      chk("in_hold", {dut.infl_v, dut.u_skid.hold_v}, 2'b01);
      tick(1'b1, 1'b0, 32'h0, 0);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("redir_tgt", 32'h40);
      tick(1'b1, 1'b0, 32'h0, 1);

      // Misaligned redirect
      tick(1'b1, 1'b1, 32'h23, 0);
      chk("err_before", fetch_err, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 0);
      chk("err_set", fetch_err, 1'b1);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("misal", 32'h20);
      tick(1'b1, 1'b0, 32'h0, 1);

      // Stream across the imem alias boundary
      tick(1'b1, 1'b1, 32'h1F8, 0);
      tick(1'b1, 1'b0, 32'h0, 0);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("pre_alias0", 32'h1F8);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("pre_alias1", 32'h1FC);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("alias", 32'h200);
      chk("alias_addr", imem_addr, 7'd1);

      // 32-bit PC wrap
      tick(1'b1, 1'b1, 32'hFFFF_FFFC, 0);
      tick(1'b1, 1'b0, 32'h0, 0);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("wrap0", 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("wrap1", 32'h0);
      chk("err_sticky", fetch_err, 1'b1);

      // Asynchronous reset mid-stream
      repeat (3) tick(1'b1, 1'b0, 32'h0, 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_kill", inst_valid, 1'b0);
      chk("err_clr", fetch_err, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      restart(RESET_PC);
      #1;
      chk("rel2_valid", inst_valid, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 1);
      chk_out("after_rst", RESET_PC);

      // Random ready/redirect traffic with periodic mid-stream resets
      prev_v  = 1'b0;
      prev_r  = 1'b0;
      prev_rv = 1'b0;
      prev_pc = 32'h0;
      for (int i = 0; i < 10000; i++) begin
         if (i % 2500 == 1250) begin
            @(negedge clk);
            inst_ready = 1'($urandom_range(0, 1));
            #2 reset = 1'b1;
            #1;
            chk("rand_async_kill", inst_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            restart(RESET_PC);
            prev_v  = 1'b0;
            prev_rv = 1'b0;
         end
         rdy = 1'($urandom_range(0, 1));
         rv  = ($urandom_range(0, 39) == 0);
         rpc = $urandom & 32'hFFFF_FFFC;
         tick(rdy, rv, rpc, -1);
         if (rv || prev_rv) begin
            chk("rand_redir_kill", inst_valid, 1'b0);
         end else if (prev_v && !prev_r) begin
            chk("rand_hold_v", inst_valid, 1'b1);
            chk("rand_hold_pc", inst_pc, prev_pc);
         end
         chk("rand_state", dut.infl_v & dut.u_skid.hold_v, 1'b0);
         prev_v  = inst_valid;
         prev_r  = inst_ready;
         prev_rv = rv;
         prev_pc = inst_pc;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
